// File: rtl/a2bus_host.sv
// Apple II host-side bus cycle generator: drives one slot with C7M-accurate PHI0/PHI1 timing.
// Optional STRETCH_EN inserts an S3X phase every STRETCH_PERIOD bus cycles.
module a2bus_host #(
  parameter int          SLOT           = 1,
  parameter logic [15:0] IDLE_ADDR      = 16'h0000,
  parameter int          STRETCH_PERIOD = 65
) (
  input  logic        C7M,
  input  logic        nRES,
  input  logic        req,
  input  logic [15:0] cmd_addr,
  input  logic        cmd_we,
  input  logic [7:0]  cmd_wdata,
  output logic        ack,
  output logic [7:0]  rdata,
  output logic        rvalid,
  output logic        rinh,
  output logic        PHI0,
  output logic        PHI1,
  output logic [15:0] A,
  output logic        nWE,
  output logic [7:0]  D_out,
  output logic        D_oe,
  input  logic [7:0]  D_in,
  input  logic        nINH,
  output logic        nDEVSEL,
  output logic        nIOSEL,
  output logic        nIOSTRB,
  output logic        busy
);

  typedef enum logic [2:0] {S0, S1, S2, S3, S3X, S4, S5, S6} phase_t;

  localparam logic [11:0] DEV_BASE = 12'hC08 + 12'(SLOT);
  localparam logic [7:0]  IO_BASE  = 8'hC0 + 8'(SLOT);

  phase_t      s, s_nxt;
  logic        stretch;
  logic        pending;
  logic        exec_vld;
  logic [15:0] pend_addr;
  logic        pend_we;
  logic [7:0]  pend_wdata;
  logic        phi0_act;

`ifdef STRETCH_EN
  localparam int CW = (STRETCH_PERIOD > 1) ? $clog2(STRETCH_PERIOD) : 1;
  logic [CW-1:0] scnt;

  always_ff @(posedge C7M or negedge nRES) begin
    if (!nRES) begin
      scnt <= '0;
    end else if (s == S6) begin
      scnt <= (scnt == CW'(STRETCH_PERIOD - 1)) ? '0 : scnt + 1'b1;
    end
  end

  assign stretch = (scnt == CW'(STRETCH_PERIOD - 1));
`else
  assign stretch = 1'b0;
`endif

  always_comb begin
    s_nxt = S0;
    unique case (s)
      S0:      s_nxt = S1;
      S1:      s_nxt = S2;
      S2:      s_nxt = S3;
      S3:      s_nxt = stretch ? S3X : S4;
      S3X:     s_nxt = S4;
      S4:      s_nxt = S5;
      S5:      s_nxt = S6;
      S6:      s_nxt = S0;
      default: s_nxt = S0;
    endcase
  end

  // ack is combinational so a request seen in S6 can still claim the cycle starting at the next edge
  assign ack      = req & ~pending & nRES;
  assign busy     = pending | exec_vld;
  assign phi0_act = (s == S4) || (s == S5) || (s == S6);
  assign PHI0     = phi0_act;
  assign PHI1     = ~phi0_act;

  assign nDEVSEL  = ~(phi0_act && (A[15:4] == DEV_BASE));
  assign nIOSEL   = ~(phi0_act && (A[15:8] == IO_BASE));
  assign nIOSTRB  = ~(phi0_act && (A[15:11] == 5'b11001));
  assign D_oe     = phi0_act & ~nWE;

  // Latched command payload carries no reset; pending qualifies it
  always_ff @(posedge C7M) begin
    if (ack && s != S6) begin
      pend_addr  <= cmd_addr;
      pend_we    <= cmd_we;
      pend_wdata <= cmd_wdata;
    end
  end

  always_ff @(posedge C7M or negedge nRES) begin
    if (!nRES) begin
      s        <= S0;
      A        <= IDLE_ADDR;
      nWE      <= 1'b1;
      D_out    <= 8'h00;
      rdata    <= 8'h00;
      rvalid   <= 1'b0;
      rinh     <= 1'b0;
      pending  <= 1'b0;
      exec_vld <= 1'b0;
    end else begin
      s      <= s_nxt;
      rvalid <= 1'b0;
      if (s == S6) begin
        if (nWE) begin
          rdata <= D_in;
          rinh  <= ~nINH;
        end
        rvalid <= exec_vld & nWE;
        // Edge entering S0: queued command first, then a fresh request, else idle read
        if (pending) begin
          A        <= pend_addr;
          nWE      <= ~pend_we;
          D_out    <= pend_we ? pend_wdata : 8'h00;
          exec_vld <= 1'b1;
          pending  <= 1'b0;
        end else if (ack) begin
          A        <= cmd_addr;
          nWE      <= ~cmd_we;
          D_out    <= cmd_we ? cmd_wdata : 8'h00;
          exec_vld <= 1'b1;
        end else begin
          A        <= IDLE_ADDR;
          nWE      <= 1'b1;
          D_out    <= 8'h00;
          exec_vld <= 1'b0;
        end
      end else if (ack) begin
        pending <= 1'b1;
      end
    end
  end

endmodule
